// File: rtl/cva6_lsu_mem_pkg.sv
// Shared types and constants for the CVA6 LSU memory responder.
package cva6_lsu_mem_pkg;

    // Longest programmable latency and the countdown width that still
    // holds MAX_LAT-1 plus the optional +3 jitter.
    localparam int unsigned MAX_LAT    = 15;
    localparam int unsigned CNT_W      = 5;

    // Widest request address the queue entries can carry.
    localparam int unsigned ADDR_MAX_W = 64;

    // Seed loaded into the jitter LFSR on reset.
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // One slot of a per-channel latency queue.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] addr;
        logic [CNT_W-1:0]      cnt;
    } lsu_mem_entry_t;

endpackage

// File: rtl/cva6_lsu_resp_channel.sv
// One in-order latency queue: entries count down independently, but only
// the head may respond, so completion order always matches push order.
module cva6_lsu_resp_channel
    import cva6_lsu_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [CNT_W-1:0]       lat_i,
    output logic                   full_o,
    output logic                   resp_o,
    output logic [ADDR_W-1:0]      resp_addr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    lsu_mem_entry_t   entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;

    assign full_o      = (count == (PTR_W+1)'(DEPTH));
    assign push_ok     = push_i && !full_o;
    assign resp_o      = entries[rd_ptr].valid && (entries[rd_ptr].cnt == '0);
    assign resp_addr_o = resp_o ? entries[rd_ptr].addr[ADDR_W-1:0] : '0;
    assign count_o     = count;

    // Countdown of every live entry, head pop on response, tail push on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries[i].valid && (entries[i].cnt != '0)) begin
                    entries[i].cnt <= entries[i].cnt - 1'b1;
                end
            end
            if (resp_o) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= rd_ptr + 1'b1;
            end
            // A push never targets the slot being popped: push needs !full,
            // and wr_ptr == rd_ptr when not full means the head slot is empty.
            if (push_ok) begin
                entries[wr_ptr].valid <= 1'b1;
                entries[wr_ptr].addr  <= ADDR_MAX_W'(addr_i);
                entries[wr_ptr].cnt   <= lat_i;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            case ({push_ok, resp_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// Deterministic memory-side responder for the CVA6 LSU model/shim.
// Loads and stores are steered into two independent in-order latency
// queues; each returns a one-cycle completion pulse LAT cycles after accept.
// Optional feature: define CVA6_LSU_MEM_JITTER_EN to add 0..3 cycles of
// LFSR-driven extra latency per request (order is still preserved).
module cva6_lsu_mem_responder
    import cva6_lsu_mem_pkg::*;
#(
    parameter int unsigned LOAD_LAT  = 3,
    parameter int unsigned STORE_LAT = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic                   req_is_load_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    output logic                   req_ready_o,
    output logic                   load_mem_resp_o,
    output logic [ADDR_W-1:0]      load_resp_addr_o,
    output logic                   store_mem_resp_o,
    output logic [ADDR_W-1:0]      store_resp_addr_o,
    output logic [$clog2(DEPTH):0] load_outstanding_o,
    output logic [$clog2(DEPTH):0] store_outstanding_o
);

    if (LOAD_LAT < 1 || LOAD_LAT > MAX_LAT) begin : g_bad_load_lat
        $error("LOAD_LAT must be within 1..15");
    end
    if (STORE_LAT < 1 || STORE_LAT > MAX_LAT) begin : g_bad_store_lat
        $error("STORE_LAT must be within 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (ADDR_W < 1 || ADDR_W > ADDR_MAX_W) begin : g_bad_addr_w
        $error("ADDR_W must be within 1..64");
    end

    // The countdown is loaded with LAT-1 so the pulse lands LAT cycles after accept.
    localparam logic [CNT_W-1:0] LOAD_BASE  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] STORE_BASE = CNT_W'(STORE_LAT - 1);

    logic             load_full;
    logic             store_full;
    logic             load_push;
    logic             store_push;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    assign req_ready_o = req_is_load_i ? !load_full : !store_full;
    assign load_push   = req_valid_i &&  req_is_load_i && req_ready_o;
    assign store_push  = req_valid_i && !req_is_load_i && req_ready_o;

`ifdef CVA6_LSU_MEM_JITTER_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign load_cnt  = LOAD_BASE  + CNT_W'(lfsr[1:0]);
    assign store_cnt = STORE_BASE + CNT_W'(lfsr[1:0]);
`else
    assign load_cnt  = LOAD_BASE;
    assign store_cnt = STORE_BASE;
`endif

    cva6_lsu_resp_channel #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_load_ch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (load_push),
        .addr_i      (req_addr_i),
        .lat_i       (load_cnt),
        .full_o      (load_full),
        .resp_o      (load_mem_resp_o),
        .resp_addr_o (load_resp_addr_o),
        .count_o     (load_outstanding_o)
    );

    cva6_lsu_resp_channel #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store_ch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (store_push),
        .addr_i      (req_addr_i),
        .lat_i       (store_cnt),
        .full_o      (store_full),
        .resp_o      (store_mem_resp_o),
        .resp_addr_o (store_resp_addr_o),
        .count_o     (store_outstanding_o)
    );

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Bench for cva6_lsu_mem_responder: two instances (short and long latency),
// a queue-based reference model checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_cva6_lsu_mem_responder;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: LOAD_LAT=3, STORE_LAT=2.  Instance B: LOAD_LAT=STORE_LAT=5.
    logic        a_rst, a_valid, a_is_load, a_ready, a_ld_resp, a_st_resp;
    logic [31:0] a_addr, a_ld_addr, a_st_addr;
    logic [2:0]  a_ld_out, a_st_out;
    logic        b_rst, b_valid, b_is_load, b_ready, b_ld_resp, b_st_resp;
    logic [31:0] b_addr, b_ld_addr, b_st_addr;
    logic [2:0]  b_ld_out, b_st_out;

    cva6_lsu_mem_responder #(
        .LOAD_LAT (3), .STORE_LAT (2), .DEPTH (DEPTH), .ADDR_W (32)
    ) u_dut_a (
        .clk_i (clk), .rst_i (a_rst),
        .req_valid_i (a_valid), .req_is_load_i (a_is_load), .req_addr_i (a_addr),
        .req_ready_o (a_ready),
        .load_mem_resp_o (a_ld_resp), .load_resp_addr_o (a_ld_addr),
        .store_mem_resp_o (a_st_resp), .store_resp_addr_o (a_st_addr),
        .load_outstanding_o (a_ld_out), .store_outstanding_o (a_st_out)
    );

    cva6_lsu_mem_responder #(
        .LOAD_LAT (5), .STORE_LAT (5), .DEPTH (DEPTH), .ADDR_W (32)
    ) u_dut_b (
        .clk_i (clk), .rst_i (b_rst),
        .req_valid_i (b_valid), .req_is_load_i (b_is_load), .req_addr_i (b_addr),
        .req_ready_o (b_ready),
        .load_mem_resp_o (b_ld_resp), .load_resp_addr_o (b_ld_addr),
        .store_mem_resp_o (b_st_resp), .store_resp_addr_o (b_st_addr),
        .load_outstanding_o (b_ld_out), .store_outstanding_o (b_st_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model. Channels: 0 = A load, 1 = A store, 2 = B load,
    // 3 = B store. Each is a FIFO of (addr, accept cycle); a request must
    // complete exactly LAT cycles after it was accepted (LAT..LAT+3 with
    // jitter, in push order).
    // ---------------------------------------------------------------
    int unsigned lat_of [4] = '{3, 2, 5, 5};
    logic [31:0] m_addr [4][16];
    int unsigned m_t    [4][16];
    int unsigned m_head [4] = '{0, 0, 0, 0};
    int unsigned m_size [4] = '{0, 0, 0, 0};
    logic [1:0]  model_ok = 2'b00;

    always @(negedge clk) begin
        logic [3:0]  d_resp;
        logic [31:0] d_addr [4];
        int unsigned d_out  [4];
        logic [1:0]  i_v, i_ld, i_rst, i_rdy, acc;
        logic [31:0] i_addr [2];
        int unsigned tgt [2];
        int unsigned age;
        logic        exp_r;
        int unsigned h;

        d_resp = {b_st_resp, b_ld_resp, a_st_resp, a_ld_resp};
        d_addr[0] = a_ld_addr; d_addr[1] = a_st_addr;
        d_addr[2] = b_ld_addr; d_addr[3] = b_st_addr;
        d_out[0] = 32'(a_ld_out); d_out[1] = 32'(a_st_out);
        d_out[2] = 32'(b_ld_out); d_out[3] = 32'(b_st_out);
        i_v = {b_valid, a_valid};   i_ld = {b_is_load, a_is_load};
        i_rst = {b_rst, a_rst};     i_rdy = {b_ready, a_ready};
        i_addr[0] = a_addr;         i_addr[1] = b_addr;

        for (int i = 0; i < 2; i++) begin
            tgt[i] = i_ld[i] ? 2 * i : 2 * i + 1;
            acc[i] = 1'b0;
            if (model_ok[i]) begin
                check($sformatf("inst%0d ready", i), 64'(i_rdy[i]), 64'(m_size[tgt[i]] < DEPTH));
                acc[i] = i_v[i] && !i_rst[i] && (m_size[tgt[i]] < DEPTH);
            end
        end

        for (int c = 0; c < 4; c++) begin
            if (model_ok[c / 2]) begin
                h = m_head[c];
                check($sformatf("ch%0d outstanding", c), 64'(d_out[c]), 64'(m_size[c]));
`ifdef CVA6_LSU_MEM_JITTER_EN
                if (m_size[c] == 0) begin
                    check($sformatf("ch%0d resp", c), 64'(d_resp[c]), 64'(0));
                end else begin
                    age = cyc - m_t[c][h];
                    if (age < lat_of[c])
                        check($sformatf("ch%0d early resp", c), 64'(d_resp[c]), 64'(0));
                    else if (age >= lat_of[c] + 3)
                        check($sformatf("ch%0d late resp", c), 64'(d_resp[c]), 64'(1));
                end
                exp_r = d_resp[c] && (m_size[c] != 0);
                check($sformatf("ch%0d resp_addr", c), 64'(d_addr[c]), exp_r ? 64'(m_addr[c][h]) : 64'(0));
`else
                exp_r = (m_size[c] != 0) && (cyc - m_t[c][h] == lat_of[c]);
                check($sformatf("ch%0d resp", c), 64'(d_resp[c]), 64'(exp_r));
                check($sformatf("ch%0d resp_addr", c), 64'(d_addr[c]), exp_r ? 64'(m_addr[c][h]) : 64'(0));
`endif
                if (exp_r) begin
                    m_head[c] = (m_head[c] + 1) % 16;
                    m_size[c] = m_size[c] - 1;
                end
            end
        end

        for (int i = 0; i < 2; i++) begin
            if (i_rst[i]) begin
                m_size[2 * i] = 0;     m_size[2 * i + 1] = 0;
                m_head[2 * i] = 0;     m_head[2 * i + 1] = 0;
                model_ok[i] = 1'b1;
            end else if (acc[i]) begin
                h = (m_head[tgt[i]] + m_size[tgt[i]]) % 16;
                m_addr[tgt[i]][h] = i_addr[i];
                m_t[tgt[i]][h]    = cyc;
                m_size[tgt[i]]    = m_size[tgt[i]] + 1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic v, input logic ld, input logic [31:0] ad);
        a_valid = v; a_is_load = ld; a_addr = ad;
    endtask

    task automatic b_req(input logic v, input logic ld, input logic [31:0] ad);
        b_valid = v; b_is_load = ld; b_addr = ad;
    endtask

    int unsigned st_occ [6] = '{0, 1, 2, 2, 1, 0};

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_req(1'b0, 1'b0, 32'h0); b_req(1'b0, 1'b0, 32'h0);
        repeat (3) step();
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst a ready", 64'(a_ready), 64'(1));
        check("rst a ld_out", 64'(a_ld_out), 64'(0));
        check("rst a st_out", 64'(a_st_out), 64'(0));
        check("rst a ld_resp", 64'(a_ld_resp), 64'(0));
        check("rst a st_addr", 64'(a_st_addr), 64'(0));
        check("rst b ready", 64'(b_ready), 64'(1));
        step();

        // Single load 0xcad: pulse exactly 3 cycles after accept.
        a_req(1'b1, 1'b1, 32'hcad);
        @(negedge clk);
        check("t1 ready", 64'(a_ready), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            step();
            a_req(1'b0, 1'b0, 32'h0);
            @(negedge clk);
`ifndef CVA6_LSU_MEM_JITTER_EN
            check("t1 ld_resp", 64'(a_ld_resp), 64'(k == 3));
            check("t1 ld_addr", 64'(a_ld_addr), (k == 3) ? 64'h cad : 64'h0);
`endif
            check("t1 st_resp", 64'(a_st_resp), 64'(0));
        end
        step();

        // Back-to-back stores 0x100/0x104/0x108 with STORE_LAT=2.
        for (int k = 0; k < 6; k++) begin
            if (k < 3) a_req(1'b1, 1'b0, 32'h100 + 32'(4 * k));
            else       a_req(1'b0, 1'b0, 32'h0);
            @(negedge clk);
`ifndef CVA6_LSU_MEM_JITTER_EN
            check("t2 st_out", 64'(a_st_out), 64'(st_occ[k]));
            check("t2 st_resp", 64'(a_st_resp), 64'(k >= 2 && k <= 4));
            check("t2 st_addr", 64'(a_st_addr), (k >= 2 && k <= 4) ? 64'(32'h100 + 32'(4 * (k - 2))) : 64'h0);
`endif
            step();
        end
        a_req(1'b0, 1'b0, 32'h0);

        // Full load queue on B (LOAD_LAT=5, DEPTH=4).
        for (int k = 0; k < 4; k++) begin
            b_req(1'b1, 1'b1, 32'h200 + 32'(4 * k));
            @(negedge clk);
            check("t3 fill ready", 64'(b_ready), 64'(1));
            step();
        end
        b_req(1'b1, 1'b1, 32'h210);
        @(negedge clk);
        check("t3 full ready", 64'(b_ready), 64'(0));
        check("t3 full ld_out", 64'(b_ld_out), 64'(4));
        step();
        b_req(1'b1, 1'b0, 32'h300);
        @(negedge clk);
        check("t3 store while full", 64'(b_ready), 64'(1));
`ifndef CVA6_LSU_MEM_JITTER_EN
        check("t3 first pop", 64'(b_ld_resp), 64'(1));
        check("t3 first pop addr", 64'(b_ld_addr), 64'h200);
`endif
        step();
        b_req(1'b1, 1'b1, 32'h210);
        @(negedge clk);
`ifndef CVA6_LSU_MEM_JITTER_EN
        check("t3 5th load ready", 64'(b_ready), 64'(1));
        check("t3 ld_out after pop", 64'(b_ld_out), 64'(3));
`endif
        step();
        b_req(1'b0, 1'b0, 32'h0);
        repeat (12) step();

        // Load then store on A: LOAD_LAT=3 and STORE_LAT=2 land together.
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      a_req(1'b1, 1'b1, 32'h400);
            else if (k == 1) a_req(1'b1, 1'b0, 32'h500);
            else             a_req(1'b0, 1'b0, 32'h0);
            @(negedge clk);
`ifndef CVA6_LSU_MEM_JITTER_EN
            check("t4 ld_resp", 64'(a_ld_resp), 64'(k == 3));
            check("t4 st_resp", 64'(a_st_resp), 64'(k == 3));
            check("t4 st_addr", 64'(a_st_addr), (k == 3) ? 64'h500 : 64'h0);
`endif
            step();
        end
        a_req(1'b0, 1'b0, 32'h0);

        // Reset with three loads pending on B.
        for (int k = 0; k < 3; k++) begin
            b_req(1'b1, 1'b1, 32'h600 + 32'(4 * k));
            step();
        end
        b_req(1'b0, 1'b1, 32'h0);
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        @(negedge clk);
        check("t5 ready", 64'(b_ready), 64'(1));
        check("t5 ld_out", 64'(b_ld_out), 64'(0));
        check("t5 st_out", 64'(b_st_out), 64'(0));
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            check("t5 no ld_resp", 64'(b_ld_resp), 64'(0));
        end
        step();

        // Random traffic on A, mostly loads.
        for (int k = 0; k < 40; k++) begin
            a_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom);
            step();
        end
        a_req(1'b0, 1'b0, 32'h0);
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
